lsu_mem_port: RTL

Load/store unit front-end: the initiator side of the CPU's byte-addressed data-memory port. Accepts one load or store per handshake from the execute stage and drives the memory's addr/write_data/data_mask/write_en/read_en port. Returns sign- or zero-extended load data to writeback. A multi-cycle FSM splits misaligned accesses into byte beats, or flags them when splitting is compiled out.

---
 rtl/lsu_mem_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
//------------------------------------------------------------------------------
// Module  : lsu_mem_port
// Brief   : Load/store front-end driving a byte-addressed data-memory port.
//           LSU_MISALIGN_SPLIT_EN splits misaligned accesses into byte beats;
//           when it is undefined, misaligned requests are flagged instead.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_misaligned,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_write_data,
  output logic [1:0]  o_mem_data_mask,
  output logic        o_mem_write_en,
  output logic        o_mem_read_en,
  input  logic [31:0] i_mem_read_data
);

  localparam logic [1:0] MEM_MASK_BYTE = 2'b01;
  localparam logic [1:0] MEM_MASK_HALF = 2'b10;
  localparam logic [1:0] MEM_MASK_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_asm;
  logic        w_fire;
  logic        w_req_misal;
  logic        w_last;
  logic        w_rsp_mis;
  logic [31:0] w_rdata_ext;

  assign w_fire      = i_req_valid && o_req_ready;
  assign w_req_misal = ((i_req_size == MEM_MASK_HALF) && i_req_addr[0]) ||
                       ((i_req_size == MEM_MASK_WORD) && (i_req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic       r_split;
  logic [1:0] r_beat;
  logic [1:0] w_beat_max;

  assign w_beat_max = (r_size == MEM_MASK_HALF) ? 2'd1 : 2'd3;
  assign w_last     = !r_split || (r_beat == w_beat_max);
  assign w_rsp_mis  = 1'b0;
`else
  logic r_misal;

  assign w_last    = 1'b1;
  assign w_rsp_mis = r_misal;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_req_ready      = 1'b0;
    o_rsp_valid      = 1'b0;
    o_rsp_rdata      = 32'd0;
    o_rsp_misaligned = 1'b0;
    o_mem_addr       = 32'd0;
    o_mem_write_data = 32'd0;
    o_mem_data_mask  = 2'b00;
    o_mem_write_en   = 1'b0;
    o_mem_read_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = !rst;
        if (w_fire) begin
          if (i_req_size == 2'b00) begin
            w_state_nxt = S_RESP;
          end else if (w_req_misal) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            w_state_nxt = S_ACCESS;
`else
            w_state_nxt = S_RESP;
`endif
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        o_mem_addr       = r_addr;
        o_mem_write_data = r_wdata;
        o_mem_data_mask  = r_size;
        o_mem_write_en   = r_we;
        o_mem_read_en    = !r_we;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (r_split) begin
          // Address arithmetic wraps naturally at 2^32.
          o_mem_addr       = r_addr + {30'd0, r_beat};
          o_mem_write_data = {24'd0, r_wdata[{r_beat, 3'b000} +: 8]};
          o_mem_data_mask  = MEM_MASK_BYTE;
        end
`endif
        if (w_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid      = 1'b1;
        o_rsp_rdata      = w_rdata_ext;
        o_rsp_misaligned = w_rsp_mis;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata_ext = 32'd0;
    if (!r_we && !w_rsp_mis) begin
      case (r_size)
        MEM_MASK_BYTE: w_rdata_ext = {{24{!r_unsigned && r_asm[7]}}, r_asm[7:0]};
        MEM_MASK_HALF: w_rdata_ext = {{16{!r_unsigned && r_asm[15]}}, r_asm[15:0]};
        MEM_MASK_WORD: w_rdata_ext = r_asm;
        default:       w_rdata_ext = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_asm      <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split    <= 1'b0;
      r_beat     <= 2'd0;
`else
      r_misal    <= 1'b0;
`endif
    end else if (w_fire) begin
      r_we       <= i_req_we;
      r_size     <= i_req_size;
      r_unsigned <= i_req_unsigned;
      r_addr     <= i_req_addr;
      r_wdata    <= i_req_wdata;
      r_asm      <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split    <= w_req_misal;
      r_beat     <= 2'd0;
`else
      r_misal    <= w_req_misal;
`endif
    end else if (r_state == S_ACCESS) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_split) begin
        if (!r_we) begin
          r_asm[{r_beat, 3'b000} +: 8] <= i_mem_read_data[7:0];
        end
        r_beat <= r_beat + 2'd1;
      end else if (!r_we) begin
        r_asm <= i_mem_read_data;
      end
`else
      if (!r_we) begin
        r_asm <= i_mem_read_data;
      end
`endif
    end
  end

endmodule

`default_nettype wire
